// File: rtl/add_initiator_if.sv
// Handshake bundle between add_initiator, its command source, the 64-bit adder and the result sink.
// The master modport is the initiator's own view; slave is the environment's view.
interface add_initiator_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [63:0] cmd_a;
  logic [63:0] cmd_b;
  logic [63:0] cmd_step;
  logic [15:0] cmd_count;
  logic        req_valid;
  logic [63:0] req_in_1;
  logic [63:0] req_in_2;
  logic [63:0] resp_result;
  logic        res_valid;
  logic        res_ready;
  logic [63:0] res_data;
  logic        res_last;
  logic        busy;
  logic        err;

  modport master (
    input  cmd_valid, cmd_a, cmd_b, cmd_step, cmd_count, resp_result, res_ready,
    output cmd_ready, req_valid, req_in_1, req_in_2, res_valid, res_data, res_last, busy, err
  );

  modport slave (
    output cmd_valid, cmd_a, cmd_b, cmd_step, cmd_count, resp_result, res_ready,
    input  cmd_ready, req_valid, req_in_1, req_in_2, res_valid, res_data, res_last, busy, err
  );
endinterface

// File: rtl/add_initiator.sv
// Request-side driver for the registered 64-bit adder: expands a command into per-element requests,
// buffers results with credit-based throttling. Optional result check enabled by ADD_INIT_CHECK_EN.
module add_initiator #(
  parameter int LATENCY    = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic            clk,
  input  logic            reset,
  add_initiator_if.master bus
);
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1) + 1;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

  state_t                r_state;
  logic [63:0]           r_step;
  logic [63:0]           r_req_in_1;
  logic [63:0]           r_req_in_2;
  logic [15:0]           r_remaining;
  logic [LATENCY-1:0]    r_sh_vld;
  logic [LATENCY-1:0]    r_sh_last;
  logic [CW-1:0]         r_inflight;
  logic [CW-1:0]         r_occ;
  logic [PW-1:0]         r_wr_ptr;
  logic [PW-1:0]         r_rd_ptr;
  logic [63:0]           r_mem_data [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] r_mem_last;

  logic          w_accept;
  logic          w_credit;
  logic          w_issue;
  logic          w_issue_last;
  logic          w_push;
  logic          w_pop;
  logic [CW-1:0] w_occ_nxt;

  // Credit covers both requests still inside the adder and results waiting in the buffer.
  assign w_accept     = (r_state == IDLE) && bus.cmd_valid;
  assign w_credit     = (r_inflight + r_occ) < CW'(FIFO_DEPTH);
  assign w_issue      = (r_state == ISSUE) && w_credit;
  assign w_issue_last = w_issue && (r_remaining == 16'd1);
  assign w_push       = r_sh_vld[LATENCY-1];
  assign w_pop        = (r_occ != '0) && bus.res_ready;
  assign w_occ_nxt    = r_occ + CW'(w_push) - CW'(w_pop);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= IDLE;
      r_step      <= '0;
      r_req_in_1  <= '0;
      r_req_in_2  <= '0;
      r_remaining <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept && (bus.cmd_count != 16'd0)) begin
            r_req_in_1  <= bus.cmd_a;
            r_req_in_2  <= bus.cmd_b;
            r_step      <= bus.cmd_step;
            r_remaining <= bus.cmd_count;
            r_state     <= ISSUE;
          end
        end
        ISSUE: begin
          if (w_issue) begin
            r_remaining <= r_remaining - 16'd1;
            // Operands of the final element stay on the bus after it is issued.
            if (w_issue_last) r_state <= DRAIN;
            else              r_req_in_1 <= r_req_in_1 + r_step;
          end
        end
        DRAIN: begin
          if ((r_inflight == '0) && (w_occ_nxt == '0)) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sh_vld   <= '0;
      r_sh_last  <= '0;
      r_inflight <= '0;
    end else begin
      r_sh_vld[0]  <= w_issue;
      r_sh_last[0] <= w_issue_last;
      for (int k = 1; k < LATENCY; k++) begin
        r_sh_vld[k]  <= r_sh_vld[k-1];
        r_sh_last[k] <= r_sh_last[k-1];
      end
      r_inflight <= r_inflight + CW'(w_issue) - CW'(w_push);
    end
  end

  // Result buffer; push-to-full is excluded by the credit check.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_occ      <= '0;
      r_mem_last <= '0;
      for (int k = 0; k < FIFO_DEPTH; k++) r_mem_data[k] <= '0;
    end else begin
      if (w_push) begin
        r_mem_data[r_wr_ptr] <= bus.resp_result;
        r_mem_last[r_wr_ptr] <= r_sh_last[LATENCY-1];
        r_wr_ptr             <= r_wr_ptr + PW'(1);
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + PW'(1);
      r_occ <= w_occ_nxt;
    end
  end

`ifdef ADD_INIT_CHECK_EN
  logic [63:0] r_chk [LATENCY];
  logic        r_err;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_err <= 1'b0;
      for (int k = 0; k < LATENCY; k++) r_chk[k] <= '0;
    end else begin
      r_chk[0] <= r_req_in_1 + r_req_in_2;
      for (int k = 1; k < LATENCY; k++) r_chk[k] <= r_chk[k-1];
      if (w_push && (r_chk[LATENCY-1] != bus.resp_result)) r_err <= 1'b1;
    end
  end

  assign bus.err = r_err;
`else
  assign bus.err = 1'b0;
`endif

  assign bus.cmd_ready = (r_state == IDLE);
  assign bus.req_valid = w_issue;
  assign bus.req_in_1  = r_req_in_1;
  assign bus.req_in_2  = r_req_in_2;
  assign bus.res_valid = (r_occ != '0);
  assign bus.res_data  = r_mem_data[r_rd_ptr];
  assign bus.res_last  = r_mem_last[r_rd_ptr] && (r_occ != '0);
  assign bus.busy      = (r_state != IDLE);
endmodule

// File: tb/tb_add_initiator.sv
// Directed bench for add_initiator: vector table for streaming commands plus hand-written
// sequences for zero count, backpressure, mid-command reset and (optionally) the result check.
module tb_add_initiator;
  localparam int LAT = 2;
  localparam int DEP = 4;

  typedef struct packed {
    logic [63:0]       a;
    logic [63:0]       b;
    logic [63:0]       step;
    logic [15:0]       count;
    logic [3:0][63:0]  exp;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  add_initiator_if bus_if();

  add_initiator #(.LATENCY(LAT), .FIFO_DEPTH(DEP)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: record request cycles and result handshakes.
  int          req_c_q[$];
  logic [63:0] res_d_q[$];
  bit          res_l_q[$];
  int          res_c_q[$];

  always @(negedge clk) begin
    if (!reset) begin
      if (bus_if.req_valid) req_c_q.push_back(cyc);
      if (bus_if.res_valid && bus_if.res_ready) begin
        res_d_q.push_back(bus_if.res_data);
        res_l_q.push_back(bus_if.res_last);
        res_c_q.push_back(cyc);
      end
    end
  end

  // Adder model: registered sum, LAT cycles; optional zeroing of one chosen element.
  logic [63:0] add_p [LAT];
  logic        add_bad [LAT];
  int          corr_base = 0;
  int          corrupt_elem = -1;

  always @(posedge clk) begin
    add_p[0]   <= bus_if.req_in_1 + bus_if.req_in_2;
    add_bad[0] <= bus_if.req_valid && ((req_c_q.size() - 1 - corr_base) == corrupt_elem);
    for (int k = 1; k < LAT; k++) begin
      add_p[k]   <= add_p[k-1];
      add_bad[k] <= add_bad[k-1];
    end
  end

  assign bus_if.resp_result = add_bad[LAT-1] ? 64'd0 : add_p[LAT-1];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic send_cmd(input logic [63:0] a, input logic [63:0] b, input logic [63:0] s,
                          input logic [15:0] c, output int acc);
    @(posedge clk);
    #1;
    bus_if.cmd_a     = a;
    bus_if.cmd_b     = b;
    bus_if.cmd_step  = s;
    bus_if.cmd_count = c;
    bus_if.cmd_valid = 1'b1;
    @(posedge clk);
    #1;
    acc = cyc;
    bus_if.cmd_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name, output int low_cyc);
    low_cyc = -1;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (!bus_if.busy) begin
        low_cyc = cyc;
        break;
      end
    end
    if (low_cyc < 0) check({name, "_timeout"}, 64'd1, 64'd0);
  endtask

  function automatic vec_t mk(logic [63:0] a, logic [63:0] b, logic [63:0] s, logic [15:0] c,
                              logic [63:0] e0, logic [63:0] e1, logic [63:0] e2, logic [63:0] e3);
    vec_t v;
    v.a = a; v.b = b; v.step = s; v.count = c;
    v.exp[0] = e0; v.exp[1] = e1; v.exp[2] = e2; v.exp[3] = e3;
    return v;
  endfunction

  task automatic reset_outputs_zero(input string tag);
    check({tag, "_req_valid"}, 64'(bus_if.req_valid), 64'd0);
    check({tag, "_res_valid"}, 64'(bus_if.res_valid), 64'd0);
    check({tag, "_res_last"},  64'(bus_if.res_last),  64'd0);
    check({tag, "_busy"},      64'(bus_if.busy),      64'd0);
    check({tag, "_err"},       64'(bus_if.err),       64'd0);
    check({tag, "_req_in_1"},  bus_if.req_in_1,       64'd0);
    check({tag, "_req_in_2"},  bus_if.req_in_2,       64'd0);
    check({tag, "_res_data"},  bus_if.res_data,       64'd0);
  endtask

  vec_t vecs[5];

  initial begin
    int acc, low, rb, qb, n, viol_rdy, viol_req, viol_res, viol_busy;

    vecs[0] = mk(64'd1, 64'd2, 64'd1, 16'd3, 64'd3, 64'd4, 64'd5, 64'd0);
    vecs[1] = mk(64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 64'd1, 16'd2, 64'd1, 64'd2, 64'd0, 64'd0);
    vecs[2] = mk(64'd10, 64'd3, 64'd5, 16'd4, 64'd13, 64'd18, 64'd23, 64'd28);
    vecs[3] = mk(64'd0, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 16'd3,
                 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFE, 64'd0);
    vecs[4] = mk(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0001, 64'd0, 16'd1,
                 64'd1, 64'd0, 64'd0, 64'd0);

    reset            = 1'b1;
    bus_if.cmd_valid = 1'b0;
    bus_if.cmd_a     = '0;
    bus_if.cmd_b     = '0;
    bus_if.cmd_step  = '0;
    bus_if.cmd_count = '0;
    bus_if.res_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset_outputs_zero("rst");
    check("rst_cmd_ready", 64'(bus_if.cmd_ready), 64'd1);
    @(posedge clk);
    #1 reset = 1'b0;

    // Streaming vectors with the sink always ready.
    bus_if.res_ready = 1'b1;
    for (int v = 0; v < 5; v++) begin
      rb = req_c_q.size();
      qb = res_d_q.size();
      send_cmd(vecs[v].a, vecs[v].b, vecs[v].step, vecs[v].count, acc);
      wait_idle($sformatf("v%0d", v), low);
      n = res_d_q.size() - qb;
      check($sformatf("v%0d_nres", v), 64'(n), 64'(vecs[v].count));
      check($sformatf("v%0d_nreq", v), 64'(req_c_q.size() - rb), 64'(vecs[v].count));
      if (n == int'(vecs[v].count) && (req_c_q.size() - rb) == n) begin
        for (int i = 0; i < n; i++) begin
          check($sformatf("v%0d_data%0d", v, i), res_d_q[qb+i], vecs[v].exp[i]);
          check($sformatf("v%0d_last%0d", v, i), 64'(res_l_q[qb+i]), 64'(i == n - 1));
        end
        check($sformatf("v%0d_first_req", v), 64'(req_c_q[rb]), 64'(acc));
        check($sformatf("v%0d_latency", v), 64'(res_c_q[qb] - req_c_q[rb]), 64'(LAT + 1));
        check($sformatf("v%0d_no_bubble", v), 64'(res_c_q[qb+n-1] - res_c_q[qb]), 64'(n - 1));
        check($sformatf("v%0d_busy_fall", v), 64'(low), 64'(res_c_q[qb+n-1] + 1));
      end
      check($sformatf("v%0d_err", v), 64'(bus_if.err), 64'd0);
    end

    // Zero-length command.
    rb = req_c_q.size();
    qb = res_d_q.size();
    send_cmd(64'd9, 64'd9, 64'd9, 16'd0, acc);
    viol_rdy = 0; viol_req = 0; viol_res = 0; viol_busy = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (!bus_if.cmd_ready) viol_rdy++;
      if (bus_if.req_valid)  viol_req++;
      if (bus_if.res_valid)  viol_res++;
      if (bus_if.busy)       viol_busy++;
    end
    check("cnt0_cmd_ready_low", 64'(viol_rdy), 64'd0);
    check("cnt0_req_valid", 64'(viol_req), 64'd0);
    check("cnt0_res_valid", 64'(viol_res), 64'd0);
    check("cnt0_busy", 64'(viol_busy), 64'd0);
    check("cnt0_nres", 64'(res_d_q.size() - qb), 64'd0);

    // Backpressure: 10 elements, sink stalled for 20 cycles.
    bus_if.res_ready = 1'b0;
    rb = req_c_q.size();
    qb = res_d_q.size();
    send_cmd(64'd100, 64'd0, 64'd1, 16'd10, acc);
    repeat (20) @(negedge clk);
    check("stall_reqs", 64'(req_c_q.size() - rb), 64'(DEP));
    check("stall_res_valid", 64'(bus_if.res_valid), 64'd1);
    check("stall_cmd_ready", 64'(bus_if.cmd_ready), 64'd0);
    check("stall_busy", 64'(bus_if.busy), 64'd1);
    check("stall_head", bus_if.res_data, 64'd100);
    @(posedge clk);
    #1 bus_if.res_ready = 1'b1;
    wait_idle("stall", low);
    n = res_d_q.size() - qb;
    check("stall_nres", 64'(n), 64'd10);
    if (n == 10) begin
      for (int i = 0; i < 10; i++) begin
        check($sformatf("stall_data%0d", i), res_d_q[qb+i], 64'(100 + i));
        check($sformatf("stall_last%0d", i), 64'(res_l_q[qb+i]), 64'(i == 9));
      end
    end

    // Asynchronous reset while results are buffered mid-command.
    bus_if.res_ready = 1'b0;
    send_cmd(64'h1000, 64'd1, 64'd1, 16'd10, acc);
    repeat (8) @(negedge clk);
    check("mid_pre_res_valid", 64'(bus_if.res_valid), 64'd1);
    #2 reset = 1'b1;
    #1;
    reset_outputs_zero("mid");
    @(posedge clk);
    #1 reset = 1'b0;
    bus_if.res_ready = 1'b1;
    rb = req_c_q.size();
    qb = res_d_q.size();
    send_cmd(64'd7, 64'd1, 64'd2, 16'd2, acc);
    wait_idle("post", low);
    repeat (10) @(negedge clk);
    n = res_d_q.size() - qb;
    check("post_nres", 64'(n), 64'd2);
    check("post_nreq", 64'(req_c_q.size() - rb), 64'd2);
    if (n == 2) begin
      check("post_data0", res_d_q[qb], 64'd8);
      check("post_data1", res_d_q[qb+1], 64'd10);
      check("post_last1", 64'(res_l_q[qb+1]), 64'd1);
    end

`ifdef ADD_INIT_CHECK_EN
    corr_base    = req_c_q.size();
    corrupt_elem = 1;
    send_cmd(64'd5, 64'd5, 64'd0, 16'd2, acc);
    wait_idle("chk", low);
    corrupt_elem = -1;
    check("chk_err_set", 64'(bus_if.err), 64'd1);
    send_cmd(64'd1, 64'd1, 64'd1, 16'd2, acc);
    wait_idle("chk2", low);
    check("chk_err_sticky", 64'(bus_if.err), 64'd1);
    @(negedge clk);
    #2 reset = 1'b1;
    #1 check("chk_err_reset", 64'(bus_if.err), 64'd0);
    @(posedge clk);
    #1 reset = 1'b0;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
